// File: rtl/maze_pkg.sv
// maze_pkg: direction codes, FSM states and neighbour offsets shared by the maze carver.
package maze_pkg;
  localparam logic [1:0] DIR_N = 2'd0, DIR_E = 2'd1, DIR_S = 2'd2, DIR_W = 2'd3;
  typedef enum logic [2:0] {IDLE, INIT, PICK, SCAN, CARVE, BACK, DONE} state_t;
  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } offset_t;
  function automatic offset_t offset(input logic [1:0] dir);
    offset_t o;
    o.dx = dir == DIR_E ? 2'sd1 : dir == DIR_W ? -2'sd1 : 2'sd0;
    o.dy = dir == DIR_S ? 2'sd1 : dir == DIR_N ? -2'sd1 : 2'sd0;
    return o;
  endfunction
endpackage

// File: rtl/carve_stack.sv
// carve_stack: LIFO of walker cells; dout shows the top entry combinationally so a pop consumes it in the same cycle.
module carve_stack #(
  parameter int DEPTH = 63,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [2**PW];
  logic [PW-1:0] sp;
  assign empty = sp == '0;
  assign dout = mem[sp - 1'b1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sp <= '0;
    else if (push) sp <= sp + 1'b1;
    else if (pop && !empty) sp <= sp - 1'b1;
  always_ff @(posedge clk)
    if (push) mem[sp] <= din;
endmodule

// File: rtl/maze_carver.sv
// maze_carver: recursive-backtracker walker over a ROWS x COLS grid, emitting one wall-removal write per carved cell.
module maze_carver
  import maze_pkg::*;
#(
  parameter int COLS = 8,
  parameter int ROWS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              rand_dir,
  output logic                    busy,
  output logic                    done,
  output logic                    wr_en,
  output logic [$clog2(COLS)-1:0] wr_x,
  output logic [$clog2(ROWS)-1:0] wr_y,
  output logic [1:0]              wr_dir,
  output logic [$clog2(COLS)-1:0] cur_x,
  output logic [$clog2(ROWS)-1:0] cur_y
);
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int N = COLS * ROWS;
  state_t state, next;
  logic [1:0] cand;
  logic [3:0] tried;
  logic [N-1:0] visited;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic [XW+YW-1:0] top;
  offset_t off;
  logic in_bounds, valid, exhausted, empty;
  assign off = offset(cand);
  // Offsets wrap modulo the grid width; only used once in_bounds holds.
  assign nx = cur_x + XW'(off.dx);
  assign ny = cur_y + YW'(off.dy);
  assign in_bounds = cand == DIR_N ? cur_y != '0 :
                     cand == DIR_S ? cur_y != YW'(ROWS - 1) :
                     cand == DIR_E ? cur_x != XW'(COLS - 1) : cur_x != '0;
  assign valid = in_bounds && !visited[{ny, nx}];
  assign exhausted = (tried | (4'b0001 << cand)) == 4'hF;
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  carve_stack #(.DEPTH(N - 1), .WIDTH(XW + YW)) u_stack (
    .clk, .rst_n, .push(state == CARVE), .pop(state == BACK),
    .din({cur_y, cur_x}), .dout(top), .empty
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE: next = start ? INIT : state;
      INIT:       next = PICK;
      PICK:       next = SCAN;
      SCAN:       next = valid ? CARVE : exhausted ? BACK : SCAN;
      CARVE:      next = PICK;
      BACK:       next = empty ? DONE : PICK;
      default:    next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cand <= '0;
      tried <= '0;
      visited <= '0;
      cur_x <= '0;
      cur_y <= '0;
      wr_en <= 1'b0;
      wr_x <= '0;
      wr_y <= '0;
      wr_dir <= '0;
    end else begin
      wr_en <= state == CARVE;
      case (state)
        INIT: begin
          visited <= N'(1);
          cur_x <= '0;
          cur_y <= '0;
          tried <= '0;
        end
        PICK: cand <= rand_dir;
        SCAN: if (!valid) begin
          tried[cand] <= 1'b1;
          cand <= cand + 2'd1;
        end
        CARVE: begin
          wr_x <= cur_x;
          wr_y <= cur_y;
          wr_dir <= cand;
          cur_x <= nx;
          cur_y <= ny;
          visited[{ny, nx}] <= 1'b1;
          tried <= '0;
        end
        BACK: if (!empty) begin
          {cur_y, cur_x} <= top;
          tried <= '0;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_maze_carver.sv
// tb_maze_carver: drives a 2x2 and an 8x8 carver and checks every write against a depth-first-search model.
module tb_maze_carver;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start2 = 1'b0, start8 = 1'b0;
  logic [1:0] rand2 = '0, rand8 = '0;
  logic busy2, done2, w2_en, busy8, done8, w8_en;
  logic [0:0] w2x, w2y, c2x, c2y;
  logic [2:0] w8x, w8y, c8x, c8y;
  logic [1:0] w2d, w8d;
  maze_carver #(.COLS(2), .ROWS(2)) d2 (
    .clk, .rst_n, .start(start2), .rand_dir(rand2), .busy(busy2), .done(done2),
    .wr_en(w2_en), .wr_x(w2x), .wr_y(w2y), .wr_dir(w2d), .cur_x(c2x), .cur_y(c2y)
  );
  maze_carver #(.COLS(8), .ROWS(8)) d8 (
    .clk, .rst_n, .start(start8), .rand_dir(rand8), .busy(busy8), .done(done8),
    .wr_en(w8_en), .wr_x(w8x), .wr_y(w8y), .wr_dir(w8d), .cur_x(c8x), .cur_y(c8y)
  );
  int checks = 0, failures = 0;
  bit vis [16][16];
  int stk_x[$], stk_y[$];
  int mx, my, nwr, held, cols, rows;
  int active = 0;
  bit lfsr_on = 1'b0;
  logic [15:0] lfsr;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit free_at(input int x, input int y, input int d);
    int nx = x + int'(d == 1) - int'(d == 3);
    int ny = y + int'(d == 2) - int'(d == 0);
    return nx >= 0 && nx < cols && ny >= 0 && ny < rows && !vis[ny][nx];
  endfunction

  function automatic bit stuck(input int x, input int y);
    for (int d = 0; d < 4; d++) if (free_at(x, y, d)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int nvis();
    int n = 0;
    for (int i = 0; i < rows; i++) for (int j = 0; j < cols; j++) n += int'(vis[i][j]);
    return n;
  endfunction

  task automatic model_start(input int c, input int r, input int h);
    cols = c; rows = r; held = h;
    vis = '{default: 0};
    vis[0][0] = 1'b1;
    stk_x.delete(); stk_y.delete();
    mx = 0; my = 0; nwr = 0;
  endtask

  task automatic on_write(input int x, input int y, input int d);
    int exp_d;
    while (stuck(mx, my) && stk_x.size() > 0) begin
      mx = stk_x.pop_back();
      my = stk_y.pop_back();
    end
    check("wr_cell", y * 16 + x, my * 16 + mx);
    if (held >= 0) begin
      exp_d = -1;
      for (int k = 0; k < 4; k++) if (exp_d < 0 && free_at(mx, my, (held + k) % 4)) exp_d = (held + k) % 4;
      check("wr_dir", d, exp_d);
    end else check("wr_legal", int'(free_at(mx, my, d)), 1);
    if (free_at(mx, my, d)) begin
      stk_x.push_back(mx); stk_y.push_back(my);
      mx += int'(d == 1) - int'(d == 3);
      my += int'(d == 2) - int'(d == 0);
      vis[my][mx] = 1'b1;
    end
    nwr++;
  endtask

  always @(negedge clk) begin
    if (active == 2 && w2_en) on_write(int'(w2x), int'(w2y), int'(w2d));
    if (active == 8 && w8_en) on_write(int'(w8x), int'(w8y), int'(w8d));
  end

  initial begin
    lfsr = 16'($urandom) | 16'h0001;
    forever begin
      @(posedge clk);
      #2;
      if (lfsr_on) begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        rand2 = lfsr[1:0];
        rand8 = lfsr[1:0];
      end
    end
  end

  function automatic bit get_done(input int sel);
    return sel == 2 ? done2 : done8;
  endfunction

  function automatic bit get_busy(input int sel);
    return sel == 2 ? busy2 : busy8;
  endfunction

  task automatic pulse(input int sel);
    @(negedge clk);
    if (sel == 2) start2 = 1'b1; else start8 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; start8 = 1'b0;
  endtask

  task automatic begin_run(input int sel, input int h);
    active = sel;
    model_start(sel, sel, h);
    lfsr_on = h < 0;
    if (h >= 0) begin rand2 = 2'(h); rand8 = 2'(h); end
    pulse(sel);
  endtask

  task automatic finish_run(input int sel);
    int cyc = 0;
    while (!get_done(sel) && cyc < 5000) begin @(negedge clk); cyc++; end
    check("done_timeout", int'(cyc < 5000), 1);
    check("write_count", nwr, sel * sel - 1);
    check("cells_reached", nvis(), sel * sel);
    check("done_high", int'(get_done(sel)), 1);
    check("busy_low", int'(get_busy(sel)), 0);
  endtask

  task automatic wait_writes(input int n);
    int cyc = 0;
    while (nwr < n && cyc < 5000) begin @(negedge clk); cyc++; end
    check("write_wait", int'(nwr >= n), 1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy8), 0);
    check("rst_done", int'(done8), 0);
    check("rst_wr_en", int'(w8_en), 0);
    check("rst_wr", int'({w8x, w8y, w8d}), 0);
    check("rst_cur", int'({c8x, c8y}), 0);
    check("rst_busy2", int'(busy2), 0);
    rst_n = 1'b1;
    begin_run(2, 1);
    finish_run(2);
    begin_run(2, 0);
    finish_run(2);
    begin_run(8, -1);
    wait_writes(5);
    pulse(8);
    finish_run(8);
    repeat (20) @(negedge clk);
    check("done_held", int'(done8), 1);
    begin_run(8, -1);
    repeat (3) @(negedge clk);
    check("done_cleared", int'(done8), 0);
    check("busy_run", int'(busy8), 1);
    finish_run(8);
    repeat (3) begin
      begin_run(8, int'($urandom_range(0, 3)));
      finish_run(8);
    end
    begin_run(2, int'($urandom_range(0, 3)));
    finish_run(2);
    begin_run(8, -1);
    wait_writes(10);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy8), 0);
    check("mid_rst_wr_en", int'(w8_en), 0);
    check("mid_rst_wr", int'({w8x, w8y, w8d}), 0);
    check("mid_rst_cur", int'({c8x, c8y}), 0);
    n = nwr;
    repeat (4) @(negedge clk);
    check("mid_rst_nowrites", nwr, n);
    check("mid_rst_done", int'(done8), 0);
    rst_n = 1'b1;
    begin_run(8, -1);
    finish_run(8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/maze_carver.md
# maze_carver

Recursive-backtracker maze generator core. Consumes the 2-bit random direction stream from the maze generator's LFSR source and walks a ROWS×COLS cell grid. Each carved passage is emitted as a one-cycle wall-removal write toward the maze memory and VGA side. It owns the visited map and the backtrack stack, and sits between the random source and the maze RAM writer.

## Interface
- COLS, 8, grid width in cells; power of two, 2–16
- ROWS, 8, grid height in cells; power of two, 2–16
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin generation; sampled only in IDLE or DONE
- rand  in  2  random direction from the random source; sampled only in PICK
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE; held until the next accepted start
- wr_en  out  1  one-cycle wall-removal strobe
- wr_x  out  $clog2(COLS)  cell column of the wall removal
- wr_y  out  $clog2(ROWS)  cell row of the wall removal
- wr_dir  out  2  wall removed: 0=N, 1=E, 2=S, 3=W
- cur_x, cur_y  out  as wr_x/wr_y  current walker cell, for debug and display

## Operation
- Coordinates: N is y−1, S is y+1, E is x+1, W is x−1. Origin (0,0) is the top-left cell.
- A neighbour is valid when it is in bounds and not yet visited.
- State machine:
  - IDLE / DONE: on start → INIT.
  - INIT: clear all visited bits; set visited[(0,0)]; cur=(0,0); sp=0; tried=0 → PICK.
  - PICK: cand ← rand; → SCAN.
  - SCAN: test the neighbour in direction cand.
    - Valid → CARVE.
    - Invalid: tried[cand] ← 1 and cand ← cand+1 mod 4. If tried|onehot(cand)==4'hF → BACK, else stay in SCAN.
  - CARVE:
    - Drive wr_en=1, wr_x/wr_y=cur, wr_dir=cand.
    - Push cur; cur ← neighbour; set visited[neighbour]; tried=0 → PICK.
  - BACK: if sp==0 → DONE; else pop into cur, tried=0 → PICK.
- Exactly ROWS×COLS−1 writes per run. The resulting maze is a spanning tree.
- Stack depth is ROWS×COLS−1 and cannot overflow by construction. A pop never occurs with sp==0.
- start asserted while busy is ignored.
- start in DONE clears done and restarts at INIT.

## Timing
- Reset values: busy=0, done=0, wr_en=0, wr_x=wr_y=wr_dir=0, cur=(0,0); state=IDLE; sp=0; visited all 0.
- start sampled in IDLE → INIT on the next edge → PICK one cycle later.
- Per carved cell: 1 PICK + 1..4 SCAN + 1 CARVE cycle.
- Per backtrack: 1 BACK, then 1 PICK + up to 4 SCAN cycles.
- wr_* outputs are registered. They are valid exactly in the cycle wr_en=1, and hold their last values otherwise.
- rand is only sampled in PICK; its value in other cycles has no effect.
- done rises in the cycle after the final BACK with sp==0. busy falls in the same cycle.
- rst_n low mid-run: immediately return to IDLE with all outputs at reset values; no further writes.

## Structure
- maze_pkg holds:
  - direction constants DIR_N/E/S/W;
  - the state enum (IDLE, INIT, PICK, SCAN, CARVE, BACK, DONE);
  - the neighbour-offset helper function.
- Sub-module carve_stack holds the LIFO:
  - parameters DEPTH and WIDTH;
  - ports push, pop, din, dout, empty;
  - registered storage, with dout valid in the same cycle as pop.

## Test plan
- Reset: hold rst_n=0 → busy=0, done=0, wr_en=0; no writes.
- COLS=ROWS=2, rand held 2'b01, pulse start → writes in order (0,0,E), (1,0,S), (1,1,W); then done=1, busy=0; exactly 3 writes.
- COLS=ROWS=2, rand held 2'b00 → the first SCAN rejects N as out of bounds; first write is (0,0,E); run completes with 3 writes.
- COLS=ROWS=8, rand driven by the LFSR source → 63 writes, each naming an in-bounds wall. The union of carved edges connects all 64 cells with no cycle. done held until the next start.
- start pulsed while busy → ignored; write count stays 63; second start after done → new run of 63 writes with done cleared during the run.
- rst_n asserted mid-run after 10 writes → outputs reset immediately. The next start produces a full fresh run of 63 writes.
